// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_pkg                                                              |
// | Shared AGC state encoding, default constants and gain-limit helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SETTLE  = 2'd3
    } agc_state_t;

    localparam int DEF_BITS        = 16;
    localparam int DEF_GAIN_BITS   = 3;
    localparam int DEF_WINDOW      = 256;
    localparam int DEF_SETTLE      = 6;
    localparam int DEF_HIGH_THRESH = 16384;
    localparam int DEF_LOW_THRESH  = 4096;
    localparam int DEF_GAIN_INIT   = 0;

    function automatic int unsigned gmax(input int unsigned gain_bits);
        return (32'd1 << gain_bits) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_peak_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_peak_detect                                                      |
// | Saturating magnitude of a signed sample and running-maximum register.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cic_peak_detect #(
    parameter int BITS = 16
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic                   clr,
    input  logic                   upd,
    input  logic signed [BITS-1:0] sample,
    output logic        [BITS-2:0] peak
);

    logic [BITS-1:0] w_neg;
    logic [BITS-2:0] w_mag;
    logic [BITS-2:0] r_peak;

    // Negating the most negative code leaves only the top bit set, so that
    // bit alone flags the case needing saturation to all ones.
    always_comb begin
        w_neg = (~sample) + 1'b1;
        w_mag = sample[BITS-2:0];
        if (sample[BITS-1]) begin
            w_mag = w_neg[BITS-1] ? {(BITS-1){1'b1}} : w_neg[BITS-2:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_peak <= '0;
        end else if (clr) begin
            r_peak <= '0;
        end else if (upd && (w_mag > r_peak)) begin
            r_peak <= w_mag;
        end
    end

    assign peak = r_peak;

endmodule
`default_nettype wire

// File: rtl/cic_agc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_agc                                                              |
// | Windowed peak-based gain stepping for the decimating CIC filter.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cic_agc
    import cic_pkg::*;
#(
    parameter int BITS        = DEF_BITS,
    parameter int GAIN_BITS   = DEF_GAIN_BITS,
    parameter int WINDOW      = DEF_WINDOW,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int HIGH_THRESH = DEF_HIGH_THRESH,
    parameter int LOW_THRESH  = DEF_LOW_THRESH,
    parameter int GAIN_INIT   = DEF_GAIN_INIT
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic signed [BITS-1:0] sample_in,
    input  logic                   sample_tick,
    input  logic                   enable,
    input  logic [GAIN_BITS-1:0]   manual_gain,
    output logic [GAIN_BITS-1:0]   gain_out,
    output logic                   gain_changed,
    output logic [BITS-2:0]        window_peak,
    output logic                   peak_valid
);

    localparam int c_cnt_max = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0]   c_win_last    = c_cnt_w'(WINDOW - 1);
    localparam logic [c_cnt_w-1:0]   c_settle_last = c_cnt_w'(SETTLE - 1);
    localparam logic [GAIN_BITS-1:0] c_gmax        = GAIN_BITS'(gmax(GAIN_BITS));
    localparam logic [GAIN_BITS-1:0] c_gain_init   = GAIN_BITS'(GAIN_INIT);
    localparam logic [BITS:0]        c_high        = (BITS+1)'(HIGH_THRESH);
    localparam logic [BITS:0]        c_low         = (BITS+1)'(LOW_THRESH);

    agc_state_t           r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [GAIN_BITS-1:0] r_gain;
    logic                 r_gain_changed;
    logic [BITS-2:0]      r_window_peak;
    logic                 r_peak_valid;

    logic [BITS-2:0]      w_peak;
    logic [BITS:0]        w_peak_ext;
    logic                 w_clr;
    logic                 w_upd;

    // The peak register only accumulates in MEASURE; every other state
    // holds it at zero so each window starts clean.
    assign w_clr      = (r_state != ST_MEASURE);
    assign w_upd      = (r_state == ST_MEASURE) && sample_tick;
    assign w_peak_ext = {2'b00, w_peak};

    cic_peak_detect #(
        .BITS (BITS)
    ) u_peak (
        .CLK    (CLK),
        .RSTb   (RSTb),
        .clr    (w_clr),
        .upd    (w_upd),
        .sample (sample_in),
        .peak   (w_peak)
    );

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_gain         <= c_gain_init;
            r_gain_changed <= 1'b0;
            r_window_peak  <= '0;
            r_peak_valid   <= 1'b0;
        end else begin
            r_gain_changed <= 1'b0;
            r_peak_valid   <= 1'b0;
            if ((r_state != ST_IDLE) && !enable) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_gain  <= manual_gain;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_gain  <= manual_gain;
                        r_count <= '0;
                        if (enable) begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (sample_tick) begin
                            if (r_count == c_win_last) begin
                                r_count <= '0;
                                r_state <= ST_DECIDE;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        r_window_peak <= w_peak;
                        r_peak_valid  <= 1'b1;
                        r_count       <= '0;
                        if ((w_peak_ext >= c_high) && (r_gain != '0)) begin
                            r_gain         <= r_gain - 1'b1;
                            r_gain_changed <= 1'b1;
                            r_state        <= ST_SETTLE;
                        end else if ((w_peak_ext < c_low) && (r_gain != c_gmax)) begin
                            r_gain         <= r_gain + 1'b1;
                            r_gain_changed <= 1'b1;
                            r_state        <= ST_SETTLE;
                        end else begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_SETTLE: begin
                        // Samples here still carry comb transients from the old gain.
                        if (sample_tick) begin
                            if (r_count == c_settle_last) begin
                                r_count <= '0;
                                r_state <= ST_MEASURE;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end
                endcase
            end
        end
    end

    assign gain_out     = r_gain;
    assign gain_changed = r_gain_changed;
    assign window_peak  = r_window_peak;
    assign peak_valid   = r_peak_valid;

endmodule
`default_nettype wire

// File: tb/tb_cic_agc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cic_agc                                                           |
// | Scoreboard bench for cic_agc with an 8-sample window.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cic_agc;

    logic               CLK = 1'b0;
    logic               RSTb;
    logic signed [15:0] sample_in;
    logic               sample_tick;
    logic               enable;
    logic [2:0]         manual_gain;
    logic [2:0]         gain_out;
    logic               gain_changed;
    logic [14:0]        window_peak;
    logic               peak_valid;

    typedef struct {
        logic [14:0] peak;
        logic [2:0]  gain;
        logic        chg;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    cic_agc #(
        .BITS        (16),
        .GAIN_BITS   (3),
        .WINDOW      (8),
        .SETTLE      (6),
        .HIGH_THRESH (16384),
        .LOW_THRESH  (4096),
        .GAIN_INIT   (0)
    ) dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .sample_in    (sample_in),
        .sample_tick  (sample_tick),
        .enable       (enable),
        .manual_gain  (manual_gain),
        .gain_out     (gain_out),
        .gain_changed (gain_changed),
        .window_peak  (window_peak),
        .peak_valid   (peak_valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic signed [15:0] value_for(input int mode, input int k);
        case (mode)
            0:       return 16'sd1000;
            1:       return 16'sd30000;
            2:       return (k % 2 == 0) ? 16'sd8000 : -16'sd8000;
            3:       return 16'sh8000;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic exp_t mk(input int p, input int g, input int c);
        exp_t e;
        e.peak = 15'(p);
        e.gain = 3'(g);
        e.chg  = 1'(c);
        return e;
    endfunction

    // One clock: drive inputs, then inspect outputs 1 time unit after the edge.
    task automatic step(input logic tick, input logic signed [15:0] val);
        exp_t e;
        sample_tick = tick;
        sample_in   = val;
        @(posedge CLK);
        #1;
        if (peak_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_peak_valid: window_peak=%0d gain_out=%0d, no window was due",
                         window_peak, gain_out);
            end else begin
                e = exp_q.pop_front();
                if (window_peak !== e.peak || gain_out !== e.gain || gain_changed !== e.chg) begin
                    miscompares++;
                    $display("FAIL window_result: got peak=%0d gain=%0d chg=%0b, expected peak=%0d gain=%0d chg=%0b",
                             window_peak, gain_out, gain_changed, e.peak, e.gain, e.chg);
                end
            end
        end else if (gain_changed !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_gain_changed: got gain_changed=%0b without peak_valid, expected 0", gain_changed);
        end
    endtask

    task automatic run_windows(input int period, input int mode, input int budget);
        int   n;
        int   k;
        logic t;
        n = 0;
        k = 0;
        while (exp_q.size() != 0 && n < budget) begin
            t = ((n % period) == 0);
            step(t, value_for(mode, k));
            if (t) k++;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL window_timeout: %0d windows outstanding after %0d cycles, expected 0",
                     exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic go_manual(input logic [2:0] g);
        enable      = 1'b0;
        manual_gain = g;
        step(1'b0, 16'sd0);
        step(1'b0, 16'sd0);
        vectors++;
        if (gain_out !== g) begin
            miscompares++;
            $display("FAIL manual_passthrough: got gain_out=%0d, expected %0d", gain_out, g);
        end
    endtask

    task automatic test_reset;
        RSTb        = 1'b0;
        enable      = 1'b0;
        manual_gain = 3'd5;
        step(1'b0, 16'sd0);
        step(1'b0, 16'sd0);
        vectors++;
        if (gain_out !== 3'd0 || gain_changed !== 1'b0 || window_peak !== 15'd0 || peak_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got gain=%0d chg=%0b peak=%0d pv=%0b, expected 0 0 0 0",
                     gain_out, gain_changed, window_peak, peak_valid);
        end
        RSTb = 1'b1;
    endtask

    task automatic test_small_input;
        go_manual(3'd0);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        for (int g = 1; g <= 7; g++) exp_q.push_back(mk(1000, g, 1));
        exp_q.push_back(mk(1000, 7, 0));
        exp_q.push_back(mk(1000, 7, 0));
        run_windows(4, 0, 1200);
    endtask

    task automatic test_large_input;
        go_manual(3'd7);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        for (int g = 6; g >= 0; g--) exp_q.push_back(mk(30000, g, 1));
        exp_q.push_back(mk(30000, 0, 0));
        exp_q.push_back(mk(30000, 0, 0));
        run_windows(1, 1, 400);
    endtask

    task automatic test_in_band;
        go_manual(3'd3);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(8000, 3, 0));
        run_windows(2, 2, 200);
    endtask

    task automatic test_neg_full_scale;
        go_manual(3'd4);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        exp_q.push_back(mk(32767, 3, 1));
        exp_q.push_back(mk(32767, 2, 1));
        run_windows(1, 3, 200);
    endtask

    task automatic test_disable_mid_window;
        int n;
        go_manual(3'd1);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'sd20000);
        manual_gain = 3'd5;
        enable      = 1'b0;
        step(1'b0, 16'sd0);
        vectors++;
        if (gain_out !== 3'd5) begin
            miscompares++;
            $display("FAIL disable_gain: got gain_out=%0d, expected 5", gain_out);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 16'sd20000);
        // A full 8-tick window ends on the 9000 sample and never sees 20000.
        enable = 1'b1;
        step(1'b0, 16'sd0);
        exp_q.push_back(mk(9000, 5, 0));
        for (int i = 0; i < 7; i++) step(1'b1, 16'sd8000);
        step(1'b1, 16'sd9000);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b1, 16'sd20000);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL reenable_timeout: %0d windows outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_in_settle;
        go_manual(3'd0);
        enable = 1'b1;
        step(1'b0, 16'sd0);
        exp_q.push_back(mk(1000, 1, 1));
        run_windows(1, 0, 100);
        step(1'b1, 16'sd1000);
        step(1'b1, 16'sd1000);
        RSTb        = 1'b0;
        manual_gain = 3'd3;
        step(1'b1, 16'sd1000);
        vectors++;
        if (gain_out !== 3'd0 || gain_changed !== 1'b0 || window_peak !== 15'd0 || peak_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_settle: got gain=%0d chg=%0b peak=%0d pv=%0b, expected 0 0 0 0",
                     gain_out, gain_changed, window_peak, peak_valid);
        end
        RSTb = 1'b1;
        step(1'b0, 16'sd0);
        vectors++;
        if (gain_out !== 3'd3) begin
            miscompares++;
            $display("FAIL idle_after_reset: got gain_out=%0d, expected 3", gain_out);
        end
        exp_q.push_back(mk(1000, 4, 1));
        run_windows(1, 0, 100);
    endtask

    initial begin
        RSTb        = 1'b0;
        sample_in   = 16'sd0;
        sample_tick = 1'b0;
        enable      = 1'b0;
        manual_gain = 3'd0;
        test_reset();
        test_small_input();
        test_large_input();
        test_in_band();
        test_neg_full_scale();
        test_disable_mid_window();
        test_reset_in_settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
